// File: rtl/phase_error_decimator.sv
// Integrate-and-dump decimator: averages 2^LOG2_DEC phase-error samples, applies a power-of-two gain.
// Define PHASE_ERROR_DECIMATOR_SAT_EN to clamp out-of-range results; otherwise they wrap (overflow_o still flags).
`timescale 1ns/1ps

module phase_error_decimator #(
    parameter int LOG2_DEC  = 4,
    parameter int GAIN_LOG2 = 0,
    parameter int DATA_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     sample_valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     valid_o,
    output logic                     overflow_o,
    output logic [LOG2_DEC-1:0]      fill_o
);

    localparam int ACC_W = DATA_W + LOG2_DEC;
    localparam int SHIFT = LOG2_DEC - GAIN_LOG2;
    localparam logic [LOG2_DEC-1:0]     CNT_LAST = '1;
    localparam logic signed [ACC_W-1:0] OUT_MAX  = {{(LOG2_DEC+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN  = {{(LOG2_DEC+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic {ST_ACCUM, ST_DUMP} state_t;

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   dump_q;
    logic [LOG2_DEC-1:0]       cnt_q;
    logic                      dump_pend_q;
    logic signed [DATA_W-1:0]  data_q;
    logic                      valid_q;
    logic                      ovf_q;

    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   scaled;
    logic                      out_of_range;

    function automatic logic signed [DATA_W-1:0] fit_out(input logic signed [ACC_W-1:0] v);
`ifdef PHASE_ERROR_DECIMATOR_SAT_EN
        if (v > OUT_MAX) return DATA_W'(OUT_MAX);
        if (v < OUT_MIN) return DATA_W'(OUT_MIN);
        return DATA_W'(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    // Sign extension into the wide accumulator means a full window can never wrap.
    assign sample_ext   = {{LOG2_DEC{sample_i[DATA_W-1]}}, sample_i};
    assign acc_d        = acc_q + sample_ext;
    assign scaled       = dump_q >>> SHIFT;
    assign out_of_range = (scaled > OUT_MAX) || (scaled < OUT_MIN);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            dump_q      <= '0;
            cnt_q       <= '0;
            dump_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (state_q == ST_DUMP) begin
                data_q  <= fit_out(scaled);
                valid_q <= 1'b1;
                state_q <= ST_ACCUM;
            end

            // The window sum waits one cycle in dump_q before the DUMP state consumes it.
            if (dump_pend_q) begin
                state_q     <= ST_DUMP;
                dump_pend_q <= 1'b0;
            end

            if (clear_i)
                ovf_q <= 1'b0;
            if (state_q == ST_DUMP && out_of_range)
                ovf_q <= 1'b1;

            if (clear_i) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (sample_valid_i) begin
                if (cnt_q == CNT_LAST) begin
                    dump_q      <= acc_d;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    dump_pend_q <= 1'b1;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
    assign fill_o     = cnt_q;

endmodule

// File: tb/tb_phase_error_decimator.sv
// Scoreboard bench for phase_error_decimator: two instances (gain 0 and gain 2, window 4) share one stimulus.
`timescale 1ns/1ps

module tb_phase_error_decimator;

    logic               clk;
    logic               rst;
    logic               clr;
    logic               sv;
    logic signed [15:0] smp;

    logic signed [15:0] data0, data1;
    logic               valid0, valid1, ovf0, ovf1;
    logic [1:0]         fill0, fill1;

    typedef struct {int sum; int due;} sb_t;
    sb_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;
    int cyc;
    int m_sum;
    int m_cnt;
    logic prev_v = 1'b0;

    phase_error_decimator #(.LOG2_DEC(2), .GAIN_LOG2(0), .DATA_W(16)) u_dut_g0 (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .sample_valid_i(sv), .sample_i(smp),
        .data_o(data0), .valid_o(valid0), .overflow_o(ovf0), .fill_o(fill0)
    );

    phase_error_decimator #(.LOG2_DEC(2), .GAIN_LOG2(2), .DATA_W(16)) u_dut_g2 (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .sample_valid_i(sv), .sample_i(smp),
        .data_o(data1), .valid_o(valid1), .overflow_o(ovf1), .fill_o(fill1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_out(input int sum, input int sh);
        int s;
        logic signed [15:0] w;
        s = sum >>> sh;
`ifdef PHASE_ERROR_DECIMATOR_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
`else
        w = s[15:0];
        return int'(w);
`endif
    endfunction

    // Reference window model, fed from the same inputs the DUTs see.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sum <= 0;
            m_cnt <= 0;
            cyc   <= 0;
            sbq.delete();
        end else begin
            cyc <= cyc + 1;
            if (clr) begin
                m_sum <= 0;
                m_cnt <= 0;
            end else if (sv) begin
                if (m_cnt == 3) begin
                    sbq.push_back(sb_t'{m_sum + int'(smp), cyc + 3});
                    m_sum <= 0;
                    m_cnt <= 0;
                end else begin
                    m_sum <= m_sum + int'(smp);
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (valid0 || valid1) begin
                check_eq("valid_pair", int'(valid1), int'(valid0));
                if (sbq.size() == 0) begin
                    check_eq("unexpected_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    n_valid++;
                    check_eq("latency", cyc, e.due);
                    check_eq("data_g0", int'(data0), exp_out(e.sum, 2));
                    check_eq("data_g2", int'(data1), exp_out(e.sum, 0));
                end
            end
            if (valid0 && prev_v)
                check_eq("valid_consecutive", 1, 0);
            prev_v = valid0;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic drive(input logic v, input int s, input logic c);
        @(negedge clk);
        sv  = v;
        smp = 16'(s);
        clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        int t1[4] = '{100, 200, 300, 400};
        int t2[4] = '{-1, -2, -2, -2};
        int wait_n;
        rst = 1'b1; sv = 1'b0; smp = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", int'(data0), 0);
        check_eq("rst_valid", int'(valid0), 0);
        check_eq("rst_ovf", int'(ovf0), 0);
        check_eq("rst_fill", int'(fill0), 0);
        check_eq("rst_data_g2", int'(data1), 0);
        rst = 1'b0;

        // Slow 1 MHz-style ticks
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t1[i], 1'b0);
            idle(49);
        end
        check_eq("t1_data", int'(data0), 250);
        check_eq("t1_ovf_g0", int'(ovf0), 0);
        check_eq("t1_ovf_g2", int'(ovf1), 0);

        // Floor rounding of a negative sum
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t2[i], 1'b0);
            idle(3);
        end
        idle(5);
        check_eq("t2_floor", int'(data0), -2);

        // Overflow on the gain-2 instance
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10000, 1'b0);
            idle(2);
        end
        idle(5);
`ifdef PHASE_ERROR_DECIMATOR_SAT_EN
        check_eq("t3_data_g2", int'(data1), 32767);
`else
        check_eq("t3_data_g2", int'(data1), -25536);
`endif
        check_eq("t3_ovf_g2", int'(ovf1), 1);
        check_eq("t3_ovf_g0", int'(ovf0), 0);
        idle(10);
        check_eq("t3_ovf_sticky", int'(ovf1), 1);

        // Back-to-back samples, no stall
        for (int i = 1; i <= 12; i++)
            drive(1'b1, i, 1'b0);
        idle(8);
        check_eq("t4_fill", int'(fill0), 0);
        check_eq("t4_data", int'(data0), 10);

        // clear_i discards the partial window and the coincident sample
        drive(1'b1, 1000, 1'b0);
        drive(1'b1, 1000, 1'b0);
        drive(1'b0, 0, 1'b0);
        check_eq("t5_fill_pre", int'(fill0), 2);
        check_eq("t5_ovf_pre", int'(ovf1), 1);
        drive(1'b1, 5000, 1'b1);
        drive(1'b0, 0, 1'b0);
        check_eq("t5_fill_clr", int'(fill0), 0);
        check_eq("t5_ovf_clr", int'(ovf1), 0);
        check_eq("t5_data_held", int'(data0), 10);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 8, 1'b0);
        idle(6);
        check_eq("t5_data", int'(data0), 8);

        // Asynchronous reset mid-window
        for (int i = 0; i < 3; i++)
            drive(1'b1, 40, 1'b0);
        drive(1'b0, 0, 1'b0);
        check_eq("t6_fill_pre", int'(fill0), 3);
        #7 rst = 1'b1;
        #1;
        check_eq("t6_data", int'(data0), 0);
        check_eq("t6_fill", int'(fill0), 0);
        check_eq("t6_valid", int'(valid0), 0);
        check_eq("t6_data_g2", int'(data1), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check_eq("t6_no_valid", n_valid, 7);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 40, 1'b0);
        idle(6);
        check_eq("t6_data_after", int'(data0), 40);

        wait_n = 0;
        while (sbq.size() != 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("drain", sbq.size(), 0);
        check_eq("valid_count", n_valid, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
